// File: rtl/wb_la_master.sv
// wb_la_master: Wishbone classic single-transfer initiator driven by a
// logic-analyzer sequencer; returns read data or a timeout error.
// Ports: wb_clk_i/wb_rst_ni (sync, active-low); cmd_* valid/ready command
// in; wbm_* Wishbone initiator; rsp_* valid/ready response out; err_cnt_o.
// Optional: define WB_LA_MASTER_TIMEOUT_EN to build the ack timeout,
// rsp_err_o generation and the saturating err_cnt_o counter.
module wb_la_master #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic [3:0]       cmd_sel_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_chk
    $error("wb_la_master: TIMEOUT out of range 2..65535");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       timeout;

  // Handshake and bus strobes come straight from the state register,
  // so reset or leaving BUS drops them on the very next edge.
  assign cmd_ready_o = (state == IDLE);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);
  assign rsp_valid_o = (state == RESP);

`ifdef WB_LA_MASTER_TIMEOUT_EN
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0]      wait_cnt;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  // Ack takes priority, so only an ack-less final cycle is a timeout.
  assign timeout   = (wait_cnt == LAST) && !wbm_ack_i;
  assign rsp_err_o = err;
  assign err_cnt_o = err_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wait_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      // Held at zero outside BUS so every transfer starts from 0.
      if (state == BUS && !wbm_ack_i)
        wait_cnt <= wait_cnt + 16'd1;
      else
        wait_cnt <= '0;
      if (state == BUS) begin
        if (wbm_ack_i) begin
          err <= 1'b0;
        end else if (timeout) begin
          err <= 1'b1;
          if (err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end
`else
  assign timeout   = 1'b0;
  assign rsp_err_o = 1'b0;
  assign err_cnt_o = '0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            rsp_dat_o <= wbm_we_o ? '0 : wbm_dat_i;
            state     <= RESP;
          end else if (timeout) begin
            rsp_dat_o <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_la_master.md
# wb_la_master

Wishbone classic single-transfer initiator for the user project area. It converts one-word read/write commands, fed from a logic-analyzer-driven sequencer, into Wishbone cycles toward the macro slaves (`macro_*`). It returns read data or a timeout error to the requester. It gives the user area a bus driver that is independent of the management SoC, for bring-up and A/B comparison of the macro variants.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of cycles `wbm_stb_o` stays asserted without an ack. Legal range is 2..65535.
- `CNT_W`, 8: width of the saturating error counter.

Ports:
- `wb_clk_i`  in  1  the single clock.
- `wb_rst_ni`  in  1  reset; synchronous, active-low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  block can accept a command.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte lane selects.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone control.
- `wbm_sel_o`  out  4  Wishbone byte selects.
- `wbm_adr_o`, `wbm_dat_o`  out  32 each  Wishbone address and write data.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_dat_i`  in  32  slave read data.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  requester consumes the response.
- `rsp_dat_o`  out  32  captured read data; 0 for writes and timeouts.
- `rsp_err_o`  out  1  transfer timed out.
- `err_cnt_o`  out  CNT_W  saturating count of timeouts.

## Operation
- The FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready_o`=1.
  - When `cmd_valid_i` is high, register `we/adr/dat/sel` into the `wbm_*` outputs and go to BUS.
- BUS:
  - `wbm_cyc_o`=`wbm_stb_o`=1.
  - The address, data, sel and we outputs stay stable for the whole state.
  - `cmd_ready_o`=0.
  - A wait counter starts at 0 on entry and increments each cycle with no ack.
- Ack in BUS:
  - Capture `wbm_dat_i` into `rsp_dat_o` for reads; set `rsp_dat_o` to 0 for writes.
  - `rsp_err_o`=0.
  - Drop cyc/stb on the next edge and go to RESP.
- Timeout in BUS:
  - Triggers when the counter equals `TIMEOUT-1` and `wbm_ack_i`=0.
  - Drop cyc/stb, set `rsp_err_o`=1 and `rsp_dat_o`=0, increment `err_cnt_o` (saturating at all-ones), go to RESP.
- Ack arriving in the same cycle as the timeout: the ack wins and no error is raised.
- RESP:
  - `rsp_valid_o`=1, with data and error held.
  - When `rsp_ready_i` is high, go to IDLE and clear `rsp_valid_o`.
  - No new command is accepted until the next IDLE cycle; the block holds one transaction at a time.
- `wbm_ack_i` outside BUS (stray ack) is ignored and has no effect on any state.
- `cmd_valid_i` while not in IDLE is ignored. The requester must hold it until it sees `cmd_ready_o`.
- `wbm_dat_o` and `wbm_we_o` are registered copies of the command. No combinational path runs from `cmd_*` to `wbm_*`.

## Timing
- Every output resets to 0: all `wbm_*`, `rsp_*`, `err_cnt_o`. The exception is `cmd_ready_o`, which is 1 on the first cycle after reset release.
- The FSM state resets to IDLE.
- Command accepted at edge N → cyc/stb high from cycle N+1.
- Zero-wait slave (ack in cycle N+1) → cyc/stb low and `rsp_valid_o`=1 in cycle N+2.
- With `rsp_ready_i` tied high → `cmd_ready_o` high in cycle N+3. Minimum throughput is one transfer per 3 cycles.
- Slave with k wait states → `rsp_valid_o` in cycle N+2+k.
- Timeout: stb is high for exactly `TIMEOUT` cycles, then `rsp_valid_o` with `rsp_err_o`=1 in the following cycle.
- Reset asserted mid-BUS: on the next edge cyc/stb drop and the state returns to IDLE. No response is generated and the pending transfer is lost.
- Reset asserted during RESP: the response is discarded.

## Configuration
- `WB_LA_MASTER_TIMEOUT_EN` defined:
  - The timeout counter, `rsp_err_o` generation and `err_cnt_o` are present as described above.
- Macro not defined:
  - No counter is built.
  - BUS waits indefinitely for `wbm_ack_i`.
  - `rsp_err_o` and `err_cnt_o` are tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Write with zero-wait slave:
  - Stimulus: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF.
  - Response: bus shows identical values while stb is high.
  - `rsp_valid_o` arrives 2 cycles after acceptance with `rsp_dat_o`=0 and `rsp_err_o`=0.
- Read with 3 wait states:
  - Stimulus: slave returns 0xCAFE_F00D.
  - Response: stb is high for 4 cycles and `rsp_dat_o`=0xCAFE_F00D.
  - Setting `rsp_ready_i` low for 5 cycles holds the response stable and keeps `cmd_ready_o`=0.
- Timeout (macro on, `TIMEOUT`=4):
  - Stimulus: no ack.
  - Response: stb is high exactly 4 cycles, then `rsp_err_o`=1, `rsp_dat_o`=0 and `err_cnt_o` goes 0→1.
  - Repeat 300 times with `CNT_W`=8: `err_cnt_o` saturates at 255.
- Ack exactly on the last timeout cycle:
  - Response: `rsp_err_o`=0, data captured, `err_cnt_o` unchanged.
- Stray ack in IDLE and RESP, plus cmd_valid pulses during BUS:
  - Response: no state change, no extra bus cycle, and the command is accepted only after the return to IDLE.
- Reset low for 1 cycle during BUS (after 2 wait cycles):
  - Response: cyc/stb are 0 on the next cycle, `rsp_valid_o` never asserts, and `cmd_ready_o`=1 once reset is released.
